// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the sram128x64 two-requester arbiter.
// Widths here match the default parameters of sram128x64_arb.
package sram_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 64;
  localparam int BYTE_W = DATA_W / 8;

  typedef enum logic {ARB_INIT, ARB_RUN} arb_state_e;

  // One requester's access, as presented to the SRAM pin mux.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] byte_en;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker. The pointer names the favoured requester and,
// after each granted access, moves to the requester that was not granted.
module sram_arb_rr (
  input  logic       clk,
  input  logic       srstn,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] grant
);

  logic ptr; // 0 favours requester 0, 1 favours requester 1

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      ptr <= 1'b0;
    end else if (adv) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/sram128x64_arb.sv
// Round-robin arbiter sharing one single-port 128x64 SRAM between m0 and m1.
// Define SRAM_ARB_INIT_EN to add a post-reset sweep writing INIT_VAL everywhere.
module sram128x64_arb
  import sram_arb_pkg::arb_state_e;
  import sram_arb_pkg::sram_req_t;
  import sram_arb_pkg::ARB_INIT;
  import sram_arb_pkg::ARB_RUN;
#(
  parameter int                ADDR_W   = sram_arb_pkg::ADDR_W,
  parameter int                DATA_W   = sram_arb_pkg::DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [7:0]        m0_byte,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [7:0]        m1_byte,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_a,
  output logic [7:0]        sram_byte,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do,
  output logic              init_busy,
  output arb_state_e        state_dbg
);

  // Handshake: m*_req is held with stable payload until m*_gnt is seen high
  // at a clock edge; that edge is the access. A read returns m*_rvalid for
  // exactly the following cycle with m*_rdata valid; writes have no response.

  arb_state_e state_q;
  logic [1:0] req;
  logic [1:0] rr_grant;
  logic [1:0] gnt;
  logic       run;
  sram_req_t  m0_r;
  sram_req_t  m1_r;
  sram_req_t  win_r;

  assign req = {m1_req, m0_req};
  assign run = (state_q == ARB_RUN);
  assign gnt = rr_grant & req & {2{run}};

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  sram_arb_rr u_rr (
    .clk   (clk),
    .srstn (srstn),
    .req   (req),
    .adv   (|gnt),
    .grant (rr_grant)
  );

  assign m0_r = '{we: m0_we, addr: m0_addr, byte_en: m0_byte, wdata: m0_wdata};
  assign m1_r = '{we: m1_we, addr: m1_addr, byte_en: m1_byte, wdata: m1_wdata};

  // Idle cycles keep we/byte low; the data bus simply parks on INIT_VAL.
  always_comb begin
    win_r = '{we: 1'b0, addr: '0, byte_en: '0, wdata: INIT_VAL};
    if (gnt[0]) begin
      win_r = m0_r;
    end else if (gnt[1]) begin
      win_r = m1_r;
    end
  end

`ifdef SRAM_ARB_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  arb_state_e        state_d;
  logic [ADDR_W-1:0] init_addr;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= ARB_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ARB_INIT && init_addr == LAST_ADDR) begin
      state_d = ARB_RUN;
    end
  end

  // Counter stops on the last address; the sweep runs once per reset.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      init_addr <= '0;
    end else if (state_q == ARB_INIT && init_addr != LAST_ADDR) begin
      init_addr <= init_addr + 1'b1;
    end
  end

  always_comb begin
    sram_cs   = |gnt;
    sram_we   = win_r.we;
    sram_a    = win_r.addr;
    sram_byte = win_r.byte_en;
    sram_di   = win_r.wdata;
    if (state_q == ARB_INIT) begin
      sram_cs   = 1'b1;
      sram_we   = 1'b1;
      sram_a    = init_addr;
      sram_byte = 8'hFF;
      sram_di   = INIT_VAL;
    end
  end
`else
  assign state_q = ARB_RUN;

  always_comb begin
    sram_cs   = |gnt;
    sram_we   = win_r.we;
    sram_a    = win_r.addr;
    sram_byte = win_r.byte_en;
    sram_di   = win_r.wdata;
  end
`endif

  assign init_busy = (state_q == ARB_INIT);
  assign state_dbg = state_q;

  // The macro registers DO, so data lines up with the cycle after the grant.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= gnt[0] & ~m0_we;
      m1_rvalid <= gnt[1] & ~m1_we;
    end
  end

  assign m0_rdata = sram_do;
  assign m1_rdata = sram_do;

endmodule

// File: tb/tb_sram128x64_arb.sv
// Self-checking bench for sram128x64_arb with a behavioural SRAM macro,
// a reference memory / round-robin model and per-requester expected queues.
module tb_sram128x64_arb;
  import sram_arb_pkg::*;

  localparam logic [63:0] TB_INIT_VAL = 64'hA5A5_5A5A_0F0F_F0F0;

  logic        clk = 1'b0;
  logic        srstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [6:0]  m0_addr, m1_addr;
  logic [7:0]  m0_byte, m1_byte;
  logic [63:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [63:0] m0_rdata, m1_rdata;
  logic        sram_cs, sram_we, init_busy;
  logic [6:0]  sram_a;
  logic [7:0]  sram_byte;
  logic [63:0] sram_di, sram_do;
  arb_state_e  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  sram128x64_arb #(.ADDR_W(7), .DATA_W(64), .INIT_VAL(TB_INIT_VAL)) dut (
    .clk(clk), .srstn(srstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byte(m0_byte),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byte(m1_byte),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a), .sram_byte(sram_byte),
    .sram_di(sram_di), .sram_do(sram_do), .init_busy(init_busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural single-port macro, DO registered
  logic [63:0] mem [0:127];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_byte[b]) mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
      end else begin
        sram_do <= mem[sram_a];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard / reference model, evaluated on the falling edge
  logic [63:0] ref_mem [0:127];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] last_rd0, last_rd1;
  logic        m_ptr, m_run, pend0, pend1, busy_prev;
  int          init_cnt, busy_cnt, cnt_rv1;

  task automatic apply_write(input logic [6:0] a, input logic [7:0] be, input logic [63:0] d);
    for (int b = 0; b < 8; b++)
      if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  always @(negedge clk) begin
    logic eg0, eg1;
    if (!srstn) begin
      m_ptr = 1'b0; pend0 = 1'b0; pend1 = 1'b0; init_cnt = 0; busy_cnt = 0;
      busy_prev = 1'b0;
      exp_q0.delete(); exp_q1.delete();
`ifdef SRAM_ARB_INIT_EN
      m_run = 1'b0;
`else
      m_run = 1'b1;
`endif
    end else begin
      check("init_busy", init_busy, !m_run);
      if (init_busy) busy_cnt++;
      if (busy_prev && !init_busy) check("init_len", busy_cnt, 128);
      busy_prev = init_busy;
      if (!m_run) begin
        check("init_cs", sram_cs, 1'b1);
        check("init_we", sram_we, 1'b1);
        check("init_a", sram_a, init_cnt);
        check("init_byte", sram_byte, 8'hFF);
        check("init_di", sram_di, TB_INIT_VAL);
      end
      check("m0_rvalid", m0_rvalid, pend0);
      check("m1_rvalid", m1_rvalid, pend1);
      if (pend0 && exp_q0.size() > 0) begin
        check("m0_rdata", m0_rdata, exp_q0.pop_front());
        last_rd0 = m0_rdata;
      end
      if (pend1 && exp_q1.size() > 0) begin
        check("m1_rdata", m1_rdata, exp_q1.pop_front());
        last_rd1 = m1_rdata;
      end
      if (m1_rvalid) cnt_rv1++;
      eg0 = 1'b0; eg1 = 1'b0;
      if (m_run) begin
        if (m0_req && m1_req) begin eg0 = !m_ptr; eg1 = m_ptr; end
        else begin eg0 = m0_req; eg1 = m1_req; end
      end
      check("m0_gnt", m0_gnt, eg0);
      check("m1_gnt", m1_gnt, eg1);
      if (m_run) begin
        check("sram_cs", sram_cs, eg0 | eg1);
        if (eg0) begin
          check("pin_a0", sram_a, m0_addr); check("pin_we0", sram_we, m0_we);
          if (m0_we) begin
            check("pin_be0", sram_byte, m0_byte); check("pin_di0", sram_di, m0_wdata);
          end
        end else if (eg1) begin
          check("pin_a1", sram_a, m1_addr); check("pin_we1", sram_we, m1_we);
          if (m1_we) begin
            check("pin_be1", sram_byte, m1_byte); check("pin_di1", sram_di, m1_wdata);
          end
        end else begin
          check("idle_we", sram_we, 1'b0); check("idle_byte", sram_byte, 8'h00);
        end
      end
      pend0 = eg0 && !m0_we;
      pend1 = eg1 && !m1_we;
      if (pend0) exp_q0.push_back(ref_mem[m0_addr]);
      if (pend1) exp_q1.push_back(ref_mem[m1_addr]);
      if (eg0 && m0_we) apply_write(m0_addr, m0_byte, m0_wdata);
      if (eg1 && m1_we) apply_write(m1_addr, m1_byte, m1_wdata);
      if (eg0 || eg1) m_ptr = eg0;
      if (!m_run) begin
        if (init_cnt == 127) begin
          m_run = 1'b1;
          for (int a = 0; a < 128; a++) ref_mem[a] = TB_INIT_VAL;
        end else begin
          init_cnt++;
        end
      end
    end
  end

  // driver: one access on requester m, held until granted
  task automatic m_access(input int m, input logic we, input logic [6:0] a,
                          input logic [7:0] be, input logic [63:0] d);
    int waited = 0;
    bit got;
    if (m == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_byte = be; m0_wdata = d; end
    else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_byte = be; m1_wdata = d; end
    got = 1'b0;
    while (!got && waited < 400) begin
      @(negedge clk);
      got = (m == 0) ? m0_gnt : m1_gnt;
      waited++;
    end
    if (!got) check("gnt_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    srstn = 1'b0; cnt_rv1 = 0; last_rd0 = '0; last_rd1 = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_byte = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_byte = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid0", m0_rvalid, 1'b0);
    check("rst_rvalid1", m1_rvalid, 1'b0);
    srstn = 1'b1;

`ifdef SRAM_ARB_INIT_EN
    // request held from reset release, then the two end addresses
    m_access(0, 1'b0, 7'd0, 8'h00, '0);
    m_access(0, 1'b0, 7'd127, 8'h00, '0);
    drain();
    check("init_rd127", last_rd0, TB_INIT_VAL);
    // restart the sweep, then reset again once it reaches address 60
    @(posedge clk); #1 srstn = 1'b0;
    @(posedge clk); #1 srstn = 1'b1;
    c = 0;
    while (!(init_busy && sram_a == 7'd60) && c < 300) begin @(negedge clk); c++; end
    check("init_reach60", sram_a, 7'd60);
    @(posedge clk); #1 srstn = 1'b0;
    @(posedge clk); #1 srstn = 1'b1;
    m_access(1, 1'b0, 7'd60, 8'h00, '0);
    drain();
    check("init_rd60", last_rd1, TB_INIT_VAL);
`endif

    // lone requester write then read
    m_access(0, 1'b1, 7'd5, 8'hFF, 64'hDEAD_BEEF_0123_4567);
    m_access(0, 1'b0, 7'd5, 8'h00, '0);
    drain();
    check("t1_rdata", last_rd0, 64'hDEAD_BEEF_0123_4567);

    // byte mask
    m_access(0, 1'b1, 7'd9, 8'hFF, '1);
    m_access(0, 1'b1, 7'd9, 8'h0F, '0);
    m_access(0, 1'b0, 7'd9, 8'h00, '0);
    drain();
    check("t2_bytemask", last_rd0, 64'hFFFF_FFFF_0000_0000);

    // fill a working set, including a zero-mask write that must not change data
    for (int a = 0; a < 16; a++)
      if (a != 5 && a != 9)
        m_access(1, 1'b1, 7'(a), 8'hFF, {$urandom, $urandom});
    m_access(1, 1'b1, 7'd3, 8'h00, 64'h1234_5678_9ABC_DEF0);

    // contention: both read continuously
    fork
      begin for (int i = 0; i < 3; i++) m_access(0, 1'b0, 7'(10 + i), 8'h00, '0); end
      begin for (int i = 0; i < 3; i++) m_access(1, 1'b0, 7'(13 + i), 8'h00, '0); end
    join
    drain();

    // back-to-back reads from m1
    c = cnt_rv1;
    for (int a = 0; a < 4; a++) m_access(1, 1'b0, 7'(a), 8'h00, '0);
    drain();
    check("t4_b2b_count", cnt_rv1 - c, 4);

    // random mixed traffic on both requesters
    fork
      begin
        for (int i = 0; i < 30; i++)
          m_access(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), {$urandom, $urandom});
      end
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          m_access(1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), {$urandom, $urandom});
        end
      end
    join
    drain();

    check("q0_empty", exp_q0.size(), 0);
    check("q1_empty", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
